// File: rtl/r16_raddr_gen_if.sv
// Read-address port of the radix-16 FFT address generator: control in, bank/address out.
interface r16_raddr_gen_if #(
  parameter int A_WIDTH = 9
);
  logic               start;
  logic               stall;
  logic               BN_out;
  logic [A_WIDTH-1:0] MA_out;
  logic               valid_out;
  logic [1:0]         stage_out;
  logic               busy;
  logic               done;

  modport master (
    output start, stall,
    input  BN_out, MA_out, valid_out, stage_out, busy, done
  );

  modport slave (
    input  start, stall,
    output BN_out, MA_out, valid_out, stage_out, busy, done
  );
endinterface

// File: rtl/r16_raddr_gen.sv
// Generates per-stage read bank/address for a 1024-point radix-16 FFT; outputs registered, one cycle after the counter.
// stall freezes the counter in RUN (valid_out low, address held); a fixed idle gap follows each stage.
module r16_raddr_gen #(
  parameter int A_WIDTH   = 9,
  parameter int NUM_STAGE = 4,
  parameter int GAP       = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  r16_raddr_gen_if.slave    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int         GW         = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGE - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  logic [1:0]         state_q,     state_d;
  logic [9:0]         c_q,         c_d;
  logic [GW-1:0]      gap_q,       gap_d;
  logic [1:0]         stage_q,     stage_d;
  logic               bn_q,        bn_d;
  logic [A_WIDTH-1:0] ma_q,        ma_d;
  logic               valid_q,     valid_d;
  logic [1:0]         stage_out_q, stage_out_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic [9:0]         a;

  // Digit-reversal: rotate left by 4*stage mod 10 within the 10-bit index.
  function automatic logic [9:0] rotl10(input logic [9:0] v, input logic [1:0] s);
    logic [3:0]  r;
    logic [19:0] d;
    case (s)
      2'd0:    r = 4'd0;
      2'd1:    r = 4'd4;
      2'd2:    r = 4'd8;
      default: r = 4'd2;
    endcase
    d = {v, v} << r;
    return d[19:10];
  endfunction

  assign a = rotl10(c_q, stage_q);

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    gap_d       = gap_q;
    stage_d     = stage_q;
    bn_d        = bn_q;
    ma_d        = ma_q;
    valid_d     = 1'b0;
    stage_out_d = stage_out_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          c_d     = 10'd0;
          stage_d = 2'd0;
        end
      end

      S_RUN: begin
        if (!bus.stall) begin
          bn_d        = ^a;
          ma_d        = A_WIDTH'(a[9:1]);
          valid_d     = 1'b1;
          stage_out_d = stage_q;
          if (c_q == 10'd1023) begin
            state_d = S_GAP;
            c_d     = 10'd0;
            gap_d   = GAP_LOAD;
          end else begin
            c_d = c_q + 10'd1;
          end
        end
      end

      S_GAP: begin
        // Gap lets the write-back pipeline drain before the next stage reads.
        if (gap_q == '0) begin
          if (stage_q == LAST_STAGE) begin
            state_d = S_DONE;
          end else begin
            stage_d = stage_q + 2'd1;
            state_d = S_RUN;
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      default: begin
        done_d      = 1'b1;
        state_d     = S_IDLE;
        stage_d     = 2'd0;
        stage_out_d = 2'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      c_q         <= 10'd0;
      gap_q       <= '0;
      stage_q     <= 2'd0;
      bn_q        <= 1'b0;
      ma_q        <= '0;
      valid_q     <= 1'b0;
      stage_out_q <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      gap_q       <= gap_d;
      stage_q     <= stage_d;
      bn_q        <= bn_d;
      ma_q        <= ma_d;
      valid_q     <= valid_d;
      stage_out_q <= stage_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.BN_out    = bn_q;
  assign bus.MA_out    = ma_q;
  assign bus.valid_out = valid_q;
  assign bus.stage_out = stage_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_r16_raddr_gen.sv
// Directed bench for r16_raddr_gen: hand vectors, full transforms, stall, ignored start, mid-run reset.
module tb_r16_raddr_gen;

  localparam int NS     = 4;
  localparam int PERIOD = 1072;   // 1024 reads + 48 gap cycles per stage
  localparam int DONE_K = NS * PERIOD + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  r16_raddr_gen_if #(.A_WIDTH(9)) bus ();

  r16_raddr_gen #(.A_WIDTH(9), .NUM_STAGE(NS), .GAP(48)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] mrot(input int c, input int s);
    int r;
    int v;
    r = (4 * s) % 10;
    v = ((c << r) | (c >> (10 - r))) & 1023;
    return v[9:0];
  endfunction

  task automatic do_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.stall = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.BN_out, bus.MA_out, bus.valid_out, bus.stage_out, bus.busy, bus.done} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got BN=%0b MA=%0d v=%0b st=%0d busy=%0b done=%0b want all 0",
               bus.BN_out, bus.MA_out, bus.valid_out, bus.stage_out, bus.busy, bus.done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%0b valid=%0b want 0 0", bus.busy, bus.valid_out);
    end
  endtask

  // Hand-computed reads at chosen cycles k after the start edge.
  task automatic test_vectors();
    int       tk[9]  = '{1, 4, 1024, 1025, 1072, 1073, 1074, 2146, 3218};
    bit       tv[9]  = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
    int       tma[9] = '{0, 1, 511, 511, 511, 0, 8, 128, 2};
    bit       tbn[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    int       tst[9] = '{0, 0, 0, 0, 0, 1, 1, 2, 3};
    int       kk = 0;
    do_start();
    for (int i = 0; i < 9; i++) begin
      while (kk < tk[i]) begin
        @(negedge clk);
        kk++;
      end
      checks++;
      if (bus.valid_out !== tv[i] || bus.MA_out !== 9'(tma[i]) || bus.BN_out !== tbn[i] ||
          bus.stage_out !== 2'(tst[i]) || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL vector_k%0d got v=%0b MA=%0d BN=%0b st=%0d busy=%0b want v=%0b MA=%0d BN=%0b st=%0d busy=1",
                 tk[i], bus.valid_out, bus.MA_out, bus.BN_out, bus.stage_out, bus.busy,
                 tv[i], tma[i], tbn[i], tst[i]);
      end
    end
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  // Runs one transform against a timeline model; optional stall burst and stray start pulses.
  task automatic run_transform(input string tag, input int stall_stage, input int stall_c,
                               input int stall_len, input bit poke_start);
    int        shift = 0, stall_left, p, st, off, n_valid = 0;
    int        addr_bad = 0, ctl_bad = 0, hold_bad = 0, done_k = -1, zrun = 0;
    bit        stall_prev = 0, seen_valid = 0;
    logic [9:0] a;
    logic      last_bn = 0;
    logic [8:0] last_ma = '0;
    logic [1:0] last_st = '0;
    int        gaps[$];
    int        exp_gaps[$];
    bit        gaps_ok;

    stall_left = stall_len;
    do_start();
    for (int k = 1; k <= DONE_K + stall_len + 4 && done_k < 0; k++) begin
      @(negedge clk);
      if (stall_prev) begin
        shift++;
        if (bus.valid_out !== 1'b0 || bus.MA_out !== last_ma || bus.BN_out !== last_bn ||
            bus.stage_out !== last_st) hold_bad++;
      end else begin
        p = k - 1 - shift;
        st = p / PERIOD;
        off = p % PERIOD;
        if (st < NS && off < 1024) begin
          a = mrot(off, st);
          if (bus.valid_out !== 1'b1 || bus.MA_out !== a[9:1] || bus.BN_out !== ^a ||
              bus.stage_out !== 2'(st) || bus.busy !== 1'b1) addr_bad++;
          last_ma = a[9:1];
          last_bn = ^a;
          last_st = 2'(st);
        end else if (p == NS * PERIOD) begin
          if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.stage_out !== 2'd0 ||
              bus.valid_out !== 1'b0) ctl_bad++;
        end else begin
          if (bus.valid_out !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) ctl_bad++;
        end
      end
      if (bus.done === 1'b1) done_k = k;
      if (bus.valid_out === 1'b1) begin
        n_valid++;
        if (seen_valid && zrun > 0) gaps.push_back(zrun);
        zrun = 0;
        seen_valid = 1;
      end else if (seen_valid) begin
        zrun++;
      end
      bus.stall = 1'b0;
      if (stall_left > 0 && (k - shift) / PERIOD == stall_stage && (k - shift) % PERIOD == stall_c) begin
        bus.stall = 1'b1;
        stall_left--;
      end
      stall_prev = bus.stall;
      bus.start = poke_start && (k == 500 || k == 1040 || k == 2150);
    end
    bus.stall = 1'b0;
    bus.start = 1'b0;

    for (int s = 0; s < NS - 1; s++) begin
      if (stall_len > 0 && s == stall_stage) exp_gaps.push_back(stall_len);
      exp_gaps.push_back(48);
    end
    if (stall_len > 0 && stall_stage == NS - 1) exp_gaps.push_back(stall_len);
    gaps_ok = (gaps.size() == exp_gaps.size());
    if (gaps_ok)
      foreach (gaps[i]) if (gaps[i] != exp_gaps[i]) gaps_ok = 0;

    checks++;
    if (n_valid != 4096) begin
      errors++;
      $display("FAIL %s_valid_count got %0d want 4096", tag, n_valid);
    end
    checks++;
    if (addr_bad != 0) begin
      errors++;
      $display("FAIL %s_addresses got %0d bad reads want 0", tag, addr_bad);
    end
    checks++;
    if (ctl_bad != 0) begin
      errors++;
      $display("FAIL %s_gap_done_ctrl got %0d bad cycles want 0", tag, ctl_bad);
    end
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL %s_stall_hold got %0d bad cycles want 0", tag, hold_bad);
    end
    checks++;
    if (!gaps_ok) begin
      errors++;
      $display("FAIL %s_gap_lengths got %0d runs (first %0d) want %0d runs of 48 plus stall %0d",
               tag, gaps.size(), (gaps.size() > 0) ? gaps[0] : -1, exp_gaps.size(), stall_len);
    end
    checks++;
    if (done_k != DONE_K + stall_len) begin
      errors++;
      $display("FAIL %s_done_cycle got %0d want %0d", tag, done_k, DONE_K + stall_len);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.stage_out !== 2'd0) begin
      errors++;
      $display("FAIL %s_after_done got done=%0b busy=%0b st=%0d want 0 0 0",
               tag, bus.done, bus.busy, bus.stage_out);
    end
  endtask

  task automatic test_full_transform();
    run_transform("full", 0, 0, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_transform("stall", 2, 100, 5, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_transform("restart", 0, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    do_start();
    repeat (2106) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.stage_out !== 2'd1 || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_gap got busy=%0b st=%0d v=%0b want 1 1 0",
               bus.busy, bus.stage_out, bus.valid_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.BN_out, bus.MA_out, bus.valid_out, bus.stage_out, bus.busy, bus.done} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset got BN=%0b MA=%0d v=%0b st=%0d busy=%0b done=%0b want all 0",
               bus.BN_out, bus.MA_out, bus.valid_out, bus.stage_out, bus.busy, bus.done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL no_stray_done got %0d active cycles want 0", dones);
    end
    run_transform("post_reset", 0, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_full_transform();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
